// File: rtl/acc_drain.sv
// acc_drain: sweeps a contiguous accumulator window, streams each word through a small output FIFO
// and, when asked, zeroes every location in the cycle its read data returns.
module acc_drain #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  clear,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_en,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  output logic                  acc_mode,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = ADDR_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [LW-1:0] len_q, issued_q, idx_d, len_cur;
  logic clr_q;
  logic rd_en_q, rd_last_q, rv_q, rv_last_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
  logic wr_en_q;
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0] head;
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic [CW:0] load;
  logic active, accept, kill, push, pop, launch, last_hs;
  assign active  = (state_q == RUN) || (state_q == FLUSH);
  assign accept  = (state_q == IDLE) && start;
  assign kill    = active && abort;
  assign pop     = m_valid && m_ready;
  assign push    = rv_q && active && !abort;
  assign last_hs = pop && m_last;
  // Conservative credit: every word not yet popped (buffered, returning, or being read) holds a slot.
  assign load    = {1'b0, cnt_q} + (CW+1)'(rv_q) + (CW+1)'(rd_en_q);
  assign launch  = accept ? (length != '0)
                          : (state_q == RUN && !abort && issued_q != len_q && load < (CW+1)'(FIFO_DEPTH));
  assign idx_d   = (accept ? '0 : issued_q) + LW'(launch);
  assign len_cur = accept ? length : len_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ((length == '0) ? DONE : RUN) : IDLE;
      RUN:     state_d = abort ? DONE : (issued_q == len_q) ? FLUSH : RUN;
      FLUSH:   state_d = (abort || last_hs) ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= '0;
      clr_q     <= 1'b0;
      issued_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_last_q <= 1'b0;
      rv_q      <= 1'b0;
      rv_last_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (accept) begin
        len_q <= length;
        clr_q <= clear;
      end
      if (accept || launch) issued_q <= idx_d;
      rd_en_q   <= launch;
      if (launch) rd_addr_q <= accept ? base_addr : rd_addr_q + 1'b1;
      rd_last_q <= launch && (idx_d == len_cur);
      rv_q      <= rd_en_q;
      rv_last_q <= rd_last_q;
      // The clear-write of an in-flight read still lands even when that read is being aborted.
      wr_en_q   <= rd_en_q && clr_q;
      wr_addr_q <= rd_addr_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (kill) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + PW'(push);
      rp_q  <= rp_q + PW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= {rv_last_q, rd_rdata};
  end
  assign head     = mem[rp_q];
  assign m_valid  = cnt_q != '0;
  assign m_data   = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_last   = m_valid && head[DATA_WIDTH];
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_we    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_wdata = '0;
  assign acc_mode = 1'b0;
endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: randomized scoreboard bench for acc_drain against a behavioural RAM and stream model.
module tb_acc_drain;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int FD = 4;
  typedef struct {logic [DW-1:0] d; logic l;} beat_t;
  logic clk = 1'b0;
  logic rst, start, clear, abort, m_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0] length;
  logic busy, done, rd_en, wr_en, wr_we, acc_mode, m_valid, m_last;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_rdata = '0, wr_wdata, m_data;
  logic [DW-1:0] ram [512];
  logic [DW-1:0] golden [512];
  beat_t exp_q[$];
  logic [AW-1:0] addr_q[$];
  beat_t e;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, c0 = 0, rel;
  int rd_cnt, wr_cnt, beat_cnt, first_rd, first_v, done_rel;
  bit aborted;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0, pab = 1'b0;
  logic [DW-1:0] pd = '0;
  always #5 clk = ~clk;
  acc_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .clear(clear), .abort(abort), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_rdata(rd_rdata), .wr_en(wr_en), .wr_we(wr_we),
    .wr_addr(wr_addr), .wr_wdata(wr_wdata), .acc_mode(acc_mode), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );
  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_rdata <= ram[rd_addr];
    if (wr_en && wr_we) ram[wr_addr] <= wr_wdata;
  end
  always @(negedge clk) begin
    if (rst) pv = 1'b0;
    else begin
      rel = cyc - c0 + 1;
      if (rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = rel;
        if (addr_q.size() == 0) flag("rd_extra");
        else chk("rd_addr", DW'(rd_addr), DW'(addr_q.pop_front()));
      end
      if (wr_en) begin
        wr_cnt++;
        chk("wr_we", DW'(wr_we), 1);
        chk("wr_wdata", wr_wdata, 0);
        chk("acc_mode", DW'(acc_mode), 0);
      end
      if (m_valid && first_v < 0) first_v = rel;
      if (pv && !pr && !pab) begin
        chk("stall_valid", DW'(m_valid), 1);
        chk("stall_data", m_data, pd);
        chk("stall_last", DW'(m_last), DW'(pl));
      end
      if (m_valid && m_ready) begin
        beat_cnt++;
        if (aborted) flag("beat_after_abort");
        else if (exp_q.size() == 0) flag("beat_extra");
        else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", DW'(m_last), DW'(e.l));
        end
      end
      if (done) begin
        if (done_rel < 0) done_rel = rel;
        else flag("done_twice");
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last; pab = abort;
    end
  end
  task automatic chk_zero(input string nm);
    chk(nm, DW'({busy, done, rd_en, rd_addr, wr_en, wr_we, wr_addr, m_valid, m_last, acc_mode}), 0);
    chk({nm, "_data"}, m_data | wr_wdata, 0);
  endtask
  // Expected stream and address order follow directly from the window rule base+i mod 512.
  task automatic load_model(input logic [AW-1:0] b, input int len);
    logic [AW-1:0] a;
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < 512; k++) golden[k] = ram[k];
    for (int i = 0; i < len; i++) begin
      a = b + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back('{golden[a], i == len - 1});
    end
    rd_cnt = 0; wr_cnt = 0; beat_cnt = 0; first_rd = -1; first_v = -1; done_rel = -1;
    aborted = 0;
  endtask
  task automatic launch(input logic [AW-1:0] b, input int len, input bit clr);
    @(posedge clk); #1;
    load_model(b, len);
    base_addr = b; length = (AW+1)'(len); clear = clr; start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b0;
    base_addr = AW'($urandom); length = (AW+1)'($urandom); clear = 1'($urandom);
  endtask
  // mode 0: ready held high, 1: ready pattern 1-0-0-1 plus a start while busy, 2: random ready
  task automatic sweep(input logic [AW-1:0] b, input int len, input bit clr, input int mode, input int abort_at);
    int t, bad;
    logic [AW-1:0] a;
    launch(b, len, clr);
    t = 1;
    while (done_rel < 0 && t < 3000) begin
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 4 == 0) || (t % 4 == 3)) : 1'($urandom_range(0, 1));
      start = (mode == 1) && (t == 5);
      abort = (t == abort_at);
      if (abort) begin
        m_ready = 1'b0;
        aborted = 1;
      end
      @(posedge clk); #1;
      t++;
    end
    abort = 1'b0; start = 1'b0; m_ready = 1'b1;
    if (done_rel < 0) flag("done_timeout");
    chk("busy_after_done", DW'(busy), 0);
    chk("done_width", DW'(done), 0);
    bad = 0;
    if (abort_at == 0) begin
      chk("beats", DW'(beat_cnt), DW'(len));
      chk("scoreboard_empty", DW'(exp_q.size()), 0);
      chk("rd_count", DW'(rd_cnt), DW'(len));
      chk("wr_count", DW'(wr_cnt), clr ? DW'(len) : 0);
      if (mode == 0) begin
        chk("first_rd_cycle", DW'(first_rd), (len == 0) ? DW'(-1) : 1);
        chk("first_valid_cycle", DW'(first_v), (len == 0) ? DW'(-1) : 3);
        chk("done_cycle", DW'(done_rel), (len == 0) ? 1 : DW'(len + 3));
      end
      for (int i = 0; i < len; i++) begin
        a = b + AW'(i);
        if (ram[a] !== (clr ? '0 : golden[a])) bad++;
      end
    end else begin
      chk("abort_done_cycle", DW'(done_rel), DW'(abort_at + 1));
      chk("abort_wr_eq_rd", DW'(wr_cnt), clr ? DW'(rd_cnt) : 0);
      chk("abort_read_bound", DW'(rd_cnt <= beat_cnt + FD), 1);
      for (int i = 0; i < len; i++) begin
        a = b + AW'(i);
        if (ram[a] !== ((clr && i < rd_cnt) ? '0 : golden[a])) bad++;
      end
    end
    chk("ram_window", DW'(bad), 0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; abort = 1'b0; m_ready = 1'b1;
    base_addr = '0; length = '0;
    for (int k = 0; k < 512; k++) ram[k] = {$urandom, $urandom};
    #1;
    chk_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) ram[16 + k] = DW'(k + 1);
    sweep(9'h010, 8, 1'b0, 0, 0);
    sweep(9'h010, 8, 1'b1, 0, 0);
    sweep(9'h1FE, 4, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++) ram[16 + k] = DW'(k + 1);
    sweep(9'h010, 8, 1'b0, 1, 0);
    sweep(9'h0A0, 0, 1'b1, 0, 0);
    sweep(9'h040, 16, 1'b1, 0, 6);
    sweep(9'h0C0, 1, 1'b1, 0, 0);
    launch(9'h100, 20, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("midsweep_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sweep(9'h180, 10, 1'b1, 0, 0);
    for (int r = 0; r < 6; r++)
      sweep(AW'($urandom), $urandom_range(1, 40), 1'($urandom), 2, 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
